// File: rtl/object_draw_if.sv
// object_draw_if: ROM read port and VGA frame-buffer write port of object_draw.
//   rom_addr  : object ROM address (ROM registers it; rom_q valid next cycle)
//   rom_q     : object ROM data word
//   vga_x/y   : pixel coordinate of the current write
//   vga_color : pixel colour of the current write
//   vga_write : one-cycle write strobe per pixel
// master = object_draw side, slave = ROM / VGA adapter side.
interface object_draw_if #(
  parameter int AW = 8,
  parameter int CW = 24,
  parameter int XW = 8,
  parameter int YW = 7
);
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_q;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_color;
  logic          vga_write;

  modport master (
    output rom_addr,
    input  rom_q,
    output vga_x,
    output vga_y,
    output vga_color,
    output vga_write
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    input  vga_x,
    input  vga_y,
    input  vga_color,
    input  vga_write
  );
endinterface

// File: rtl/object_draw.sv
// object_draw: sweeps every word of an OBJ_W x OBJ_H object ROM and turns each
// one into a pixel write at (x0+col, y0+row) on the VGA frame-buffer port.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   start        : one-cycle draw request, sampled only when idle
//   erase        : write bg_color instead of the ROM colour (latched with start)
//   x0, y0       : object top-left corner (latched with start)
//   bg_color     : erase colour (latched with start)
//   bus          : ROM address/data and VGA write port (object_draw_if.master)
//   busy         : high while the sweep and pipeline drain are in progress
//   done         : one-cycle completion pulse
// Transparent words (== TRANSP, when TRANSP_EN) and pixels beyond XMAX/YMAX are
// skipped; the draw always takes the same number of cycles regardless.
module object_draw #(
  parameter int            OBJ_W     = 16,
  parameter int            OBJ_H     = 16,
  parameter int            AW        = 8,
  parameter int            CW        = 24,
  parameter int            XW        = 8,
  parameter int            YW        = 7,
  parameter int            XMAX      = 160,
  parameter int            YMAX      = 120,
  parameter logic [CW-1:0] TRANSP    = '0,
  parameter bit            TRANSP_EN = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                erase,
  input  logic [XW-1:0]       x0,
  input  logic [YW-1:0]       y0,
  input  logic [CW-1:0]       bg_color,
  object_draw_if.master       bus,
  output logic                busy,
  output logic                done
);

  localparam int CB = $clog2(OBJ_W);  // column bits of the ROM address
  localparam int RB = $clog2(OBJ_H);  // row bits of the ROM address

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Control state
  logic [1:0]    state_q,    state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          drain_q,    drain_d;

  // Request parameters captured at start
  logic [XW-1:0] x0_q,       x0_d;
  logic [YW-1:0] y0_q,       y0_d;
  logic          erase_q,    erase_d;
  logic [CW-1:0] bg_q,       bg_d;

  // Stage 1: pixel position travelling alongside the ROM access
  logic          s1_valid_q, s1_valid_d;
  logic [CB-1:0] s1_col_q,   s1_col_d;
  logic [RB-1:0] s1_row_q,   s1_row_d;

  // Stage 2: registered pixel outputs
  logic [XW-1:0] vga_x_q,     vga_x_d;
  logic [YW-1:0] vga_y_q,     vga_y_d;
  logic [CW-1:0] vga_color_q, vga_color_d;
  logic          vga_write_q, vga_write_d;

  // One extra bit so x0+col / y0+row never wrap before the bound check
  logic [XW:0] sum_x;
  logic [YW:0] sum_y;
  logic        opaque;
  logic        in_bounds;
  logic        pix_ok;

  // Stage-2 pixel decision
  always_comb begin
    sum_x     = {1'b0, x0_q} + (XW+1)'(s1_col_q);
    sum_y     = {1'b0, y0_q} + (YW+1)'(s1_row_q);
    opaque    = !(TRANSP_EN && (bus.rom_q == TRANSP));
    in_bounds = (sum_x < (XW+1)'(XMAX)) && (sum_y < (YW+1)'(YMAX));
    pix_ok    = s1_valid_q && opaque && in_bounds;

    vga_write_d = pix_ok;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    if (pix_ok) begin
      vga_x_d     = sum_x[XW-1:0];
      vga_y_d     = sum_y[YW-1:0];
      vga_color_d = erase_q ? bg_q : bus.rom_q;
    end
  end

  // Sequencer and stage 1
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    drain_d    = drain_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    erase_d    = erase_q;
    bg_d       = bg_q;
    s1_valid_d = 1'b0;
    s1_col_d   = s1_col_q;
    s1_row_d   = s1_row_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d       = x0;
          y0_d       = y0;
          erase_d    = erase;
          bg_d       = bg_color;
          rom_addr_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // The address being presented now is the pixel whose ROM word
        // appears on rom_q next cycle, so its position is tagged here.
        s1_valid_d = 1'b1;
        s1_col_d   = rom_addr_q[CB-1:0];
        s1_row_d   = rom_addr_q[CB+RB-1:CB];
        rom_addr_d = rom_addr_q + AW'(1);
        if (rom_addr_q == '1) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        // Two cycles: one for the last ROM read, one for its output register
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      drain_q     <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      erase_q     <= 1'b0;
      bg_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      drain_q     <= drain_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      erase_q     <= erase_d;
      bg_q        <= bg_d;
      s1_valid_q  <= s1_valid_d;
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_write_q <= vga_write_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.vga_x     = vga_x_q;
  assign bus.vga_y     = vga_y_q;
  assign bus.vga_color = vga_color_q;
  assign bus.vga_write = vga_write_q;

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_object_draw.sv
// tb_object_draw: directed, table-driven bench for object_draw with a
// behavioural registered ROM and a per-draw expected pixel stream.
module tb_object_draw;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        erase;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [23:0] bg;
  logic        busy;
  logic        done;

  object_draw_if #(.AW(8), .CW(24), .XW(8), .YW(7)) bus ();

  object_draw #(
    .OBJ_W(16), .OBJ_H(16), .AW(8), .CW(24), .XW(8), .YW(7),
    .XMAX(160), .YMAX(120), .TRANSP(24'h000000), .TRANSP_EN(1'b1)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .start    (start),
    .erase    (erase),
    .x0       (x0),
    .y0       (y0),
    .bg_color (bg),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Object ROM: address registered, data valid the cycle after
  logic [23:0] rom_mem [256];
  always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // 0: ROM[k] = k+1 (all opaque); 1: all transparent except ROM[17]
  task automatic load_rom(input int mode);
    for (int k = 0; k < 256; k++) begin
      if (mode == 0) rom_mem[k] = 24'(k + 1);
      else           rom_mem[k] = (k == 17) ? 24'hFF0000 : 24'h000000;
    end
  endtask

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
  } pix_t;

  // Results of the last run_draw
  int res_writes, res_busy, res_done_cyc, res_stream_err;
  int res_fcyc, res_fx, res_fy, res_fc;
  int res_lcyc, res_lx, res_ly, res_lc;

  // Starts a draw (start sampled at the next rising edge = edge 0), then
  // samples every cycle at the falling edge until done or 400 cycles pass.
  // stray1/stray2 pulse start during those cycles with a different x0.
  task automatic run_draw(input int vx0, input int vy0, input bit verase,
                          input int vbg, input int stray1, input int stray2);
    pix_t exp_q[$];
    pix_t e;
    int   cyc;
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      e.cyc = k + 3;
      e.x   = vx0 + (k % 16);
      e.y   = vy0 + (k / 16);
      e.c   = verase ? vbg : int'(rom_mem[k]);
      if (rom_mem[k] != 24'h0 && e.x < 160 && e.y < 120) exp_q.push_back(e);
    end
    res_writes = 0; res_busy = 0; res_done_cyc = -1; res_stream_err = 0;
    res_fcyc = -1; res_fx = -1; res_fy = -1; res_fc = -1;
    res_lcyc = -1; res_lx = -1; res_ly = -1; res_lc = -1;

    @(negedge clk);
    x0 = 8'(vx0); y0 = 7'(vy0); erase = verase; bg = 24'(vbg); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x0 = 8'd99; y0 = 7'd3; erase = ~verase; bg = 24'h123456;  // must be latched
    cyc = 1;
    while (cyc <= 400) begin
      if (busy) res_busy++;
      if (bus.vga_write) begin
        res_writes++;
        if (res_fcyc < 0) begin
          res_fcyc = cyc; res_fx = int'(bus.vga_x); res_fy = int'(bus.vga_y);
          res_fc = int'(bus.vga_color);
        end
        res_lcyc = cyc; res_lx = int'(bus.vga_x); res_ly = int'(bus.vga_y);
        res_lc = int'(bus.vga_color);
        if (exp_q.size() == 0) res_stream_err++;
        else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.x != int'(bus.vga_x) || e.y != int'(bus.vga_y) ||
              e.c != int'(bus.vga_color)) res_stream_err++;
        end
      end
      if (done) begin
        res_done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
      start = (cyc == stray1 || cyc == stray2);
    end
    start = 1'b0;
    res_stream_err += exp_q.size();
  endtask

  typedef struct {
    string name;
    int    mode;
    int    x0;
    int    y0;
    bit    erase;
    int    bg;
    int    writes;
    int    fcyc, fx, fy, fc;
    int    lcyc, lx, ly, lc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int wr, dn, bz;

    vecs[0] = '{"basic",  0, 10, 20, 1'b0, 0,        256,   3, 10, 20, 1,        258, 25, 35, 256};
    vecs[1] = '{"transp", 1, 10, 20, 1'b0, 0,          1,  20, 11, 21, 'hFF0000,  20, 11, 21, 'hFF0000};
    vecs[2] = '{"erase",  0, 10, 20, 1'b1, 'h00FF00, 256,   3, 10, 20, 'h00FF00, 258, 25, 35, 'h00FF00};
    vecs[3] = '{"clip",   0, 150, 110, 1'b0, 0,      100,   3, 150, 110, 1,      156, 159, 119, 'h9A};
    vecs[4] = '{"offscr", 0, 250, 5, 1'b0, 0,          0,   0, 0, 0, 0,          0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; erase = 1'b0; x0 = '0; y0 = '0; bg = '0;
    load_rom(0);
    repeat (3) @(negedge clk);
    check("rst_rom_addr", longint'(bus.rom_addr), 0);
    check("rst_vga_x", longint'(bus.vga_x), 0);
    check("rst_vga_y", longint'(bus.vga_y), 0);
    check("rst_vga_color", longint'(bus.vga_color), 0);
    check("rst_vga_write", longint'(bus.vga_write), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      load_rom(vecs[i].mode);
      run_draw(vecs[i].x0, vecs[i].y0, vecs[i].erase, vecs[i].bg, 0, 0);
      check({vecs[i].name, "_writes"}, res_writes, vecs[i].writes);
      check({vecs[i].name, "_stream"}, res_stream_err, 0);
      check({vecs[i].name, "_done_cyc"}, res_done_cyc, 259);
      check({vecs[i].name, "_busy_cycles"}, res_busy, 258);
      if (vecs[i].writes > 0) begin
        check({vecs[i].name, "_first_cyc"}, res_fcyc, vecs[i].fcyc);
        check({vecs[i].name, "_first_x"}, res_fx, vecs[i].fx);
        check({vecs[i].name, "_first_y"}, res_fy, vecs[i].fy);
        check({vecs[i].name, "_first_color"}, res_fc, vecs[i].fc);
        check({vecs[i].name, "_last_cyc"}, res_lcyc, vecs[i].lcyc);
        check({vecs[i].name, "_last_x"}, res_lx, vecs[i].lx);
        check({vecs[i].name, "_last_y"}, res_ly, vecs[i].ly);
        check({vecs[i].name, "_last_color"}, res_lc, vecs[i].lc);
      end
      @(negedge clk);
      check({vecs[i].name, "_done_width"}, longint'(done), 0);
      check({vecs[i].name, "_idle_busy"}, longint'(busy), 0);
    end

    // Start while busy is ignored; start right after done is accepted
    load_rom(0);
    run_draw(10, 20, 1'b0, 0, 50, 258);
    check("busy_start_writes", res_writes, 256);
    check("busy_start_stream", res_stream_err, 0);
    check("busy_start_done_cyc", res_done_cyc, 259);
    run_draw(40, 30, 1'b0, 0, 0, 0);
    check("after_done_writes", res_writes, 256);
    check("after_done_stream", res_stream_err, 0);
    check("after_done_first_x", res_fx, 40);
    check("after_done_last_x", res_lx, 55);
    check("after_done_done_cyc", res_done_cyc, 259);

    // Reset in the middle of a draw
    @(negedge clk);
    @(negedge clk);
    x0 = 8'd10; y0 = 7'd20; erase = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);           // now in cycle 100
    check("midrst_busy_before", longint'(busy), 1);
    check("midrst_write_before", longint'(bus.vga_write), 1);
    rst = 1'b1;
    #1;
    check("midrst_write", longint'(bus.vga_write), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_rom_addr", longint'(bus.rom_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    wr = 0; dn = 0; bz = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.vga_write) wr++;
      if (done) dn++;
      if (busy) bz++;
    end
    check("midrst_no_writes", wr, 0);
    check("midrst_no_done", dn, 0);
    check("midrst_no_busy", bz, 0);
    run_draw(10, 20, 1'b0, 0, 0, 0);
    check("midrst_fresh_writes", res_writes, 256);
    check("midrst_fresh_stream", res_stream_err, 0);
    check("midrst_fresh_done_cyc", res_done_cyc, 259);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/object_draw.md
Name: object_draw

Overview:
- Reader/consumer for the 16x16, 24-bit, 256-word object ROM: sweeps ROM addresses and turns each word into a pixel write for the VGA frame-buffer adapter.
- Sits between game/control logic and the VGA adapter write port.
- Draw mode writes ROM colour at (x0+col, y0+row); erase mode writes a background colour at the same opaque pixels.
- Transparent-colour skipping and right/bottom screen clipping.

Parameters:
- OBJ_W, 16, object width in pixels (power of 2).
- OBJ_H, 16, object height in pixels; OBJ_W*OBJ_H = 2^AW.
- AW, 8, ROM address width.
- CW, 24, colour width (matches ROM word).
- XW, 8, screen x coordinate width.
- YW, 7, screen y coordinate width.
- XMAX, 160, screen width; pixels with x >= XMAX are not written.
- YMAX, 120, screen height; pixels with y >= YMAX are not written.
- TRANSP, 24'h000000, colour treated as transparent.
- TRANSP_EN, 1, 1 = skip pixels whose ROM word equals TRANSP.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- erase  in  1  latched with start; 1 = write bg_color instead of ROM colour.
- x0  in  XW  object top-left x; latched with start.
- y0  in  YW  object top-left y; latched with start.
- bg_color  in  CW  erase colour; latched with start.
- rom_addr  out  AW  address to object ROM (ROM registers address; rom_q valid next cycle).
- rom_q  in  CW  ROM data.
- vga_x  out  XW  pixel x.
- vga_y  out  YW  pixel y.
- vga_color  out  CW  pixel colour.
- vga_write  out  1  pixel write strobe, one cycle per pixel.
- busy  out  1  high while a draw is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async): state IDLE; rom_addr=0, vga_x=0, vga_y=0, vga_color=0, vga_write=0, busy=0, done=0; pipeline valid bits cleared.
- A reset mid-draw aborts immediately. No further vga_write is issued and done is not pulsed.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - If start=1 at edge 0, latch x0, y0, erase, bg_color; rom_addr<=0; go to RUN.
  - start while not IDLE is ignored; it is not queued.
- RUN:
  - rom_addr holds k in cycle k+1, for k = 0..2^AW-1 (cycles 1..256).
  - col = k[log2(OBJ_W)-1:0], row = k[AW-1:log2(OBJ_W)] (row-major).
  - After k = 2^AW-1, go to DRAIN. rom_addr wraps to 0.
- Pipeline, 2 stages:
  - Stage 1 carries col/row alongside the ROM access.
  - Stage 2 registers outputs from rom_q.
  - Address k presented in cycle t gives vga_write for pixel k in cycle t+2.
  - Writes occur in cycles 3..258.
- Pixel k produces vga_write=1 only if all of these hold:
  - stage valid;
  - NOT (TRANSP_EN and rom_q==TRANSP);
  - x0+col < XMAX and y0+row < YMAX. Compute with XW+1 / YW+1 bits so there is no wrap-around; clipped pixels are dropped.
- Pixel outputs:
  - vga_color = erase ? bg_color : rom_q.
  - vga_x/vga_y = truncated sums.
  - When vga_write=0, the other vga_* outputs hold their last values.
- DRAIN: 2 cycles (257, 258) to empty the pipeline, then DONE.
- DONE: done=1 for one cycle (cycle 259), then IDLE. start can be accepted in the cycle after done.
- busy = 1 in RUN and DRAIN (cycles 1..258); 0 in IDLE and DONE.
- Full draw takes 259 cycles from start edge to done pulse, independent of transparency or clipping.

Test Plan:
1. Basic draw: ROM[k]=k+1, TRANSP_EN=1, x0=10, y0=20, start 1 cycle. Require exactly 256 writes, first at cycle 3 (10,20,colour 1), last at cycle 258 (25,35,colour 256); done in cycle 259; busy high for 258 cycles.
2. Transparency: ROM all 0 except ROM[17]=24'hFF0000. Require a single write (x0+1,y0+1,FF0000); done still at cycle 259.
3. Erase: same ROM as test 1, erase=1, bg_color=24'h00FF00. Require 256 writes, all with colour 00FF00, at the same coordinates as test 1.
4. Clipping: x0=150, y0=110, ROM all nonzero. Require only x 150..159 and y 110..119 written (100 writes); no vga_x wrap to small values.
5. Start while busy: second start pulses at cycles 50 and 258 are ignored. Start pulsed in the cycle after done begins a new draw with new x0.
6. Reset mid-draw: assert reset at cycle 100. Require vga_write=0 and busy=0 immediately, no done pulse, and a fresh start then completes normally.
